// File: rtl/alarm_bank.sv
// Multi-channel BCD alarm comparator with sticky flags and a masked, registered irq.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_bank #(
  parameter int NUM_ALARMS = 4,
  parameter int SEL_W      = 2,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [SEL_W-1:0]      wr_sel,
  input  logic [1:0]            wr_field,
  input  logic [7:0]            wr_data,
  input  logic [7:0]            real_min,
  input  logic [7:0]            real_hour,
  input  logic [7:0]            real_day,
  input  logic [3:0]            real_weekday,
  input  logic [NUM_ALARMS-1:0] clr,
  input  logic [NUM_ALARMS-1:0] snooze_req,
  input  logic [NUM_ALARMS-1:0] irq_mask,
  output logic [NUM_ALARMS-1:0] alarm_flag,
  output logic                  irq
);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {DISARMED, ARMED, FIRED, SNOOZE} state_t;
`else
  typedef enum logic [1:0] {DISARMED, ARMED, FIRED} state_t;
`endif

  logic [NUM_ALARMS-1:0] w_flag;
  logic                  r_irq;

`ifdef ALARM_SNOOZE_EN
  logic [6:0] r_minPrev;
  logic       w_tick;
  logic       w_unused;

  assign w_tick   = (real_min[6:0] != r_minPrev);
  assign w_unused = ^{real_min[7], real_hour[7:6], real_day[7:6], real_weekday[3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_minPrev <= '0;
    else     r_minPrev <= real_min[6:0];
  end
`else
  logic w_unused;
  assign w_unused = ^{real_min[7], real_hour[7:6], real_day[7:6], real_weekday[3], snooze_req};
`endif

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : gCh
    logic       r_minEn, r_hourEn, r_dayEn, r_wdEn;
    logic [6:0] r_minVal;
    logic [5:0] r_hourVal, r_dayVal;
    logic [2:0] r_wdVal;
    logic       r_matchQ, r_flag;
    state_t     r_state;
`ifdef ALARM_SNOOZE_EN
    logic [5:0] r_snoozeCnt;
`endif
    logic w_wrHit, w_minOn, w_minOff, w_match, w_fire, w_clrHit;
    logic w_minEq, w_hourEq, w_dayEq, w_wdEq;

    // Out-of-range selects can never equal a channel index, so they are dropped here.
    assign w_wrHit  = wr_en && (wr_sel == SEL_W'(g));
    assign w_minOn  = w_wrHit && (wr_field == 2'd0) && wr_data[7];
    assign w_minOff = w_wrHit && (wr_field == 2'd0) && !wr_data[7];

    assign w_minEq  = (r_minVal  == real_min[6:0]);
    assign w_hourEq = (r_hourVal == real_hour[5:0]);
    assign w_dayEq  = (r_dayVal  == real_day[5:0]);
    assign w_wdEq   = (r_wdVal   == real_weekday[2:0]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_minEn   <= 1'b0;
        r_minVal  <= '0;
        r_hourEn  <= 1'b0;
        r_hourVal <= '0;
        r_dayEn   <= 1'b0;
        r_dayVal  <= '0;
        r_wdEn    <= 1'b0;
        r_wdVal   <= '0;
      end else if (w_wrHit) begin
        case (wr_field)
          2'd0:    {r_minEn, r_minVal}   <= wr_data;
          2'd1:    {r_hourEn, r_hourVal} <= {wr_data[7], wr_data[5:0]};
          2'd2:    {r_dayEn, r_dayVal}   <= {wr_data[7], wr_data[5:0]};
          default: {r_wdEn, r_wdVal}     <= {wr_data[7], wr_data[2:0]};
        endcase
      end
    end

    // Day/weekday qualify only when hour is enabled; with both, either one may match.
    always_comb begin
      w_match = 1'b0;
      if (r_minEn) begin
        if (!r_hourEn)                w_match = w_minEq;
        else if (r_dayEn && r_wdEn)   w_match = w_minEq && w_hourEq && (w_dayEq || w_wdEq);
        else if (r_dayEn)             w_match = w_minEq && w_hourEq && w_dayEq;
        else if (r_wdEn)              w_match = w_minEq && w_hourEq && w_wdEq;
        else                          w_match = w_minEq && w_hourEq;
      end
    end

`ifdef ALARM_SNOOZE_EN
    assign w_fire   = w_match && !r_matchQ && (r_state == ARMED || r_state == FIRED);
    assign w_clrHit = clr[g] && (r_state == FIRED || r_state == SNOOZE);
`else
    assign w_fire   = w_match && !r_matchQ && (r_state == ARMED || r_state == FIRED);
    assign w_clrHit = clr[g] && (r_state == FIRED);
`endif

    // Priority: disable write, snooze cancel, arm, fire/expiry (set beats clear), clear, snooze.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state  <= DISARMED;
        r_flag   <= 1'b0;
        r_matchQ <= 1'b0;
`ifdef ALARM_SNOOZE_EN
        r_snoozeCnt <= '0;
`endif
      end else begin
        r_matchQ <= w_wrHit ? 1'b0 : w_match;
        if (w_minOff) begin
          r_state <= DISARMED;
          r_flag  <= 1'b0;
        end
`ifdef ALARM_SNOOZE_EN
        else if (w_wrHit && r_state == SNOOZE) begin
          r_state <= ARMED;
        end
`endif
        else if (w_minOn && r_state == DISARMED) begin
          r_state <= ARMED;
        end else if (w_fire) begin
          r_state <= FIRED;
          r_flag  <= 1'b1;
        end
`ifdef ALARM_SNOOZE_EN
        else if (r_state == SNOOZE && w_tick && r_snoozeCnt == 6'd1) begin
          r_state     <= FIRED;
          r_flag      <= 1'b1;
          r_snoozeCnt <= '0;
        end
`endif
        else if (w_clrHit) begin
          r_state <= ARMED;
          r_flag  <= 1'b0;
        end
`ifdef ALARM_SNOOZE_EN
        else if (r_state == SNOOZE && w_tick) begin
          r_snoozeCnt <= r_snoozeCnt - 6'd1;
        end else if (r_state == FIRED && snooze_req[g]) begin
          r_state     <= SNOOZE;
          r_flag      <= 1'b0;
          r_snoozeCnt <= 6'(SNOOZE_MIN);
        end
`endif
      end
    end

    assign w_flag[g] = r_flag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= |(w_flag & irq_mask);
  end

  assign alarm_flag = w_flag;
  assign irq        = r_irq;

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: each cycle pushes the expected flags/irq, which are
// popped and compared one clock later. The snooze section builds only with ALARM_SNOOZE_EN.
module tb_alarm_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_sel;
  logic [1:0] wr_field;
  logic [7:0] wr_data;
  logic [7:0] real_min, real_hour, real_day;
  logic [3:0] real_weekday;
  logic [3:0] clr, snooze_req, irq_mask;
  logic [3:0] alarm_flag;
  logic       irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] flag;
    logic       irq;
  } exp_t;

  exp_t sbQ[$];

  alarm_bank #(.NUM_ALARMS(4), .SEL_W(3), .SNOOZE_MIN(5)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_field(wr_field),
    .wr_data(wr_data), .real_min(real_min), .real_hour(real_hour), .real_day(real_day),
    .real_weekday(real_weekday), .clr(clr), .snooze_req(snooze_req), .irq_mask(irq_mask),
    .alarm_flag(alarm_flag), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExpected(input string tag, input logic [3:0] expFlag, input logic expIrq);
    exp_t e;
    e.tag  = tag;
    e.flag = expFlag;
    e.irq  = expIrq;
    sbQ.push_back(e);
  endtask

  task automatic popAndCompare();
    exp_t e;
    if (sbQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sbQ.pop_front();
      checkOutput({e.tag, "_flag"}, {28'd0, alarm_flag}, {28'd0, e.flag});
      checkOutput({e.tag, "_irq"}, {31'd0, irq}, {31'd0, e.irq});
    end
  endtask

  // One clock with the inputs already driven; pulses are dropped afterwards.
  task automatic applyStimulus(input string tag, input logic [3:0] expFlag, input logic expIrq);
    pushExpected(tag, expFlag, expIrq);
    @(posedge clk);
    #1;
    popAndCompare();
    wr_en      = 1'b0;
    clr        = '0;
    snooze_req = '0;
  endtask

  task automatic writeCfg(input string tag, input logic [2:0] sel, input logic [1:0] field,
                          input logic [7:0] data, input logic [3:0] expFlag, input logic expIrq);
    wr_en    = 1'b1;
    wr_sel   = sel;
    wr_field = field;
    wr_data  = data;
    applyStimulus(tag, expFlag, expIrq);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_field = '0; wr_data = '0;
    real_min = 8'h29; real_hour = 8'h00; real_day = 8'h01; real_weekday = 4'd1;
    clr = '0; snooze_req = '0; irq_mask = 4'b1111;
    #2;
    pushExpected("reset", 4'b0000, 1'b0);
    popAndCompare();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-minute alarm, clear while still matching.
    writeCfg("ch0_wr", 3'd0, 2'd0, 8'hB0, 4'b0000, 1'b0);
    applyStimulus("ch0_idle", 4'b0000, 1'b0);
    real_min = 8'h30;
    applyStimulus("ch0_fire", 4'b0001, 1'b0);
    applyStimulus("ch0_irq", 4'b0001, 1'b1);
    clr = 4'b0001;
    applyStimulus("ch0_clr", 4'b0000, 1'b1);
    applyStimulus("ch0_norefire", 4'b0000, 1'b0);
    applyStimulus("ch0_hold", 4'b0000, 1'b0);
    writeCfg("ch0_off", 3'd0, 2'd0, 8'h00, 4'b0000, 1'b0);

    // Minute+hour+weekday, then day/weekday OR.
    writeCfg("ch1_wrmin", 3'd1, 2'd0, 8'h95, 4'b0000, 1'b0);
    writeCfg("ch1_wrhour", 3'd1, 2'd1, 8'h87, 4'b0000, 1'b0);
    writeCfg("ch1_wrwd", 3'd1, 2'd3, 8'h83, 4'b0000, 1'b0);
    real_min = 8'h15; real_hour = 8'h07; real_weekday = 4'd2; real_day = 8'h11;
    applyStimulus("ch1_wrongwd", 4'b0000, 1'b0);
    real_weekday = 4'd3;
    applyStimulus("ch1_fire", 4'b0010, 1'b0);
    applyStimulus("ch1_irq", 4'b0010, 1'b1);
    clr = 4'b0010;
    applyStimulus("ch1_clr", 4'b0000, 1'b1);
    real_min = 8'h16;
    applyStimulus("ch1_move", 4'b0000, 1'b0);
    writeCfg("ch1_wrday", 3'd1, 2'd2, 8'h92, 4'b0000, 1'b0);
    real_min = 8'h15; real_weekday = 4'd4; real_day = 8'h12;
    applyStimulus("ch1_dayfire", 4'b0010, 1'b0);
    applyStimulus("ch1_dayirq", 4'b0010, 1'b1);
    clr = 4'b0010;
    applyStimulus("ch1_clr2", 4'b0000, 1'b1);
    writeCfg("ch1_off", 3'd1, 2'd0, 8'h00, 4'b0000, 1'b0);

    // Two channels on the same minute, irq masked to channel 2.
    irq_mask = 4'b0100;
    writeCfg("ch2_wr", 3'd2, 2'd0, 8'hC5, 4'b0000, 1'b0);
    writeCfg("ch3_wr", 3'd3, 2'd0, 8'hC5, 4'b0000, 1'b0);
    real_min = 8'h45;
    applyStimulus("dual_fire", 4'b1100, 1'b0);
    applyStimulus("dual_irq", 4'b1100, 1'b1);
    clr = 4'b0100;
    applyStimulus("mask_clr", 4'b1000, 1'b1);
    applyStimulus("mask_irqoff", 4'b1000, 1'b0);
    clr = 4'b1001;
    applyStimulus("clr_unfired", 4'b0000, 1'b0);

    // Fire and clear in the same cycle: set wins.
    real_min = 8'h46;
    applyStimulus("sim_move", 4'b0000, 1'b0);
    real_min = 8'h45;
    clr = 4'b0100;
    applyStimulus("sim_fireclr", 4'b1100, 1'b0);
    applyStimulus("sim_irq", 4'b1100, 1'b1);
    clr = 4'b1100;
    applyStimulus("sim_clr", 4'b0000, 1'b1);

    // Out-of-range select must not alias onto channel 1.
    writeCfg("sel5_wr", 3'd5, 2'd0, 8'hD0, 4'b0000, 1'b0);
    real_min = 8'h50;
    applyStimulus("sel5_nofire", 4'b0000, 1'b0);
    applyStimulus("sel5_hold", 4'b0000, 1'b0);

    // Asynchronous reset while fired with irq asserted.
    real_min = 8'h45;
    applyStimulus("rst_prefire", 4'b1100, 1'b0);
    applyStimulus("rst_preirq", 4'b1100, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    pushExpected("rst_async", 4'b0000, 1'b0);
    popAndCompare();
    @(negedge clk);
    rst = 1'b0;
    real_min = 8'h44;
    applyStimulus("rst_move", 4'b0000, 1'b0);
    real_min = 8'h45;
    applyStimulus("rst_cfgoff", 4'b0000, 1'b0);
    applyStimulus("rst_hold", 4'b0000, 1'b0);

`ifdef ALARM_SNOOZE_EN
    irq_mask = 4'b0001;
    writeCfg("sn_wr", 3'd0, 2'd0, 8'h90, 4'b0000, 1'b0);
    real_min = 8'h10;
    applyStimulus("sn_fire", 4'b0001, 1'b0);
    applyStimulus("sn_irq", 4'b0001, 1'b1);
    snooze_req = 4'b0001;
    applyStimulus("sn_req", 4'b0000, 1'b1);
    for (int m = 1; m <= 4; m++) begin
      real_min = 8'h10 + 8'(m);
      applyStimulus("sn_wait", 4'b0000, 1'b0);
    end
    real_min = 8'h15;
    applyStimulus("sn_expire", 4'b0001, 1'b0);
    applyStimulus("sn_expirq", 4'b0001, 1'b1);
    clr = 4'b0001;
    applyStimulus("sn_clr", 4'b0000, 1'b1);
    real_min = 8'h10;
    applyStimulus("sn_refire", 4'b0001, 1'b0);
    snooze_req = 4'b0001;
    applyStimulus("sn_req2", 4'b0000, 1'b1);
    real_min = 8'h11;
    applyStimulus("sn_t11", 4'b0000, 1'b0);
    real_min = 8'h12;
    clr = 4'b0001;
    applyStimulus("sn_clr12", 4'b0000, 1'b0);
    for (int m = 3; m <= 6; m++) begin
      real_min = 8'h10 + 8'(m);
      applyStimulus("sn_noexpire", 4'b0000, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
